// File: rtl/hc595_receiver.sv
// Receiver for a 74HC595-style serial display stream (srclk/rclk/dio).
// It oversamples the inputs in the local clock domain, rebuilds the seg/sel bytes and checks each frame when it is latched.
module hc595_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int FRAME_BITS     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       srclk_in,
    input  logic       rclk_in,
    input  logic       dio_in,
    output logic [7:0] seg,
    output logic [7:0] sel,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [4:0] bit_cnt
);

    localparam int IdleW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IdleW-1:0] IdleMax   = IdleW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]       FullCount = 5'(FRAME_BITS);

    logic [SYNC_STAGES-1:0] srclkSync_q, rclkSync_q, dioSync_q;
    logic                   srclkPrev_q, rclkPrev_q;
    logic                   srclkRise, rclkRise, dioSync;

    logic [FRAME_BITS-1:0]  sr_q, sr_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [IdleW-1:0]       idle_q, idle_d;
    logic [7:0]             seg_q, seg_d, sel_q, sel_d;
    logic                   valid_q, valid_d, err_q, err_d;

    // The three pipelines are the same depth so dio stays aligned with srclk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            srclkSync_q <= '0;
            rclkSync_q  <= '0;
            dioSync_q   <= '0;
            srclkPrev_q <= 1'b0;
            rclkPrev_q  <= 1'b0;
        end else begin
            srclkSync_q <= {srclkSync_q[SYNC_STAGES-2:0], srclk_in};
            rclkSync_q  <= {rclkSync_q[SYNC_STAGES-2:0], rclk_in};
            dioSync_q   <= {dioSync_q[SYNC_STAGES-2:0], dio_in};
            srclkPrev_q <= srclkSync_q[SYNC_STAGES-1];
            rclkPrev_q  <= rclkSync_q[SYNC_STAGES-1];
        end
    end

    assign srclkRise = srclkSync_q[SYNC_STAGES-1] & ~srclkPrev_q;
    assign rclkRise  = rclkSync_q[SYNC_STAGES-1] & ~rclkPrev_q;
    assign dioSync   = dioSync_q[SYNC_STAGES-1];

    // A latch always sees the pre-shift register and count, even if a shift lands in the same cycle.
    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        seg_d   = seg_q;
        sel_d   = sel_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (rclkRise) begin
            if (cnt_q == FullCount) begin
                seg_d   = sr_q[FRAME_BITS-1 -: 8];
                sel_d   = sr_q[7:0];
                valid_d = 1'b1;
            end else if (cnt_q != 5'd0) begin
                err_d = 1'b1;
            end
            cnt_d  = 5'd0;
            idle_d = '0;
        end

        if (srclkRise) begin
            sr_d   = {sr_q[FRAME_BITS-2:0], dioSync};
            idle_d = '0;
            if (rclkRise) begin
                cnt_d = 5'd1;
            end else if (cnt_q != 5'd31) begin
                cnt_d = cnt_q + 5'd1;
            end
        end else if (!rclkRise) begin
            if (cnt_q == 5'd0) begin
                idle_d = '0;
            end else if (idle_q == IdleMax) begin
                cnt_d  = 5'd0;
                idle_d = '0;
                err_d  = 1'b1;
            end else begin
                idle_d = idle_q + IdleW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q    <= '0;
            cnt_q   <= 5'd0;
            idle_q  <= '0;
            seg_q   <= 8'd0;
            sel_q   <= 8'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign seg         = seg_q;
    assign sel         = sel_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign bit_cnt     = cnt_q;

endmodule

// File: tb/tb_hc595_receiver.sv
// Scoreboard bench for hc595_receiver: stimulus pushes expected frame events,
// and a monitor pops and compares them whenever frame_valid or frame_err pulses.
module tb_hc595_receiver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       srclk_in = 1'b0;
    logic       rclk_in = 1'b0;
    logic       dio_in = 1'b0;
    logic [7:0] seg, sel;
    logic       frame_valid, frame_err;
    logic [4:0] bit_cnt;

    typedef struct {
        bit         isErr;
        logic [7:0] seg;
        logic [7:0] sel;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    hc595_receiver #(
        .SYNC_STAGES(2),
        .FRAME_BITS(16),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .srclk_in(srclk_in),
        .rclk_in(rclk_in),
        .dio_in(dio_in),
        .seg(seg),
        .sel(sel),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .bit_cnt(bit_cnt)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expectValid(input logic [7:0] s, input logic [7:0] d);
        exp_t e;
        e.isErr = 1'b0;
        e.seg   = s;
        e.sel   = d;
        expQ.push_back(e);
    endtask

    task automatic expectErr();
        exp_t e;
        e.isErr = 1'b1;
        e.seg   = 8'h00;
        e.sel   = 8'h00;
        expQ.push_back(e);
    endtask

    task automatic shiftBit(input logic b);
        dio_in = b;
        repeat (2) @(negedge clk);
        srclk_in = 1'b1;
        repeat (2) @(negedge clk);
        srclk_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [63:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) shiftBit(data[i]);
    endtask

    task automatic latchFrame();
        rclk_in = 1'b1;
        repeat (2) @(negedge clk);
        rclk_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (frame_valid && frame_err) begin
            checks++;
            errors++;
            $display("[TB] FAIL pulse_exclusive actual=both required=one");
        end else if (frame_valid || frame_err) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pulse actual valid=%b err=%b required=none",
                         frame_valid, frame_err);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                if (e.isErr != frame_err) begin
                    errors++;
                    $display("[TB] FAIL pulse_kind actual err=%b required err=%b", frame_err, e.isErr);
                end else if (!e.isErr && (seg !== e.seg || sel !== e.sel)) begin
                    errors++;
                    $display("[TB] FAIL frame_data actual=%h%h required=%h%h", seg, sel, e.seg, e.sel);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_seg", {8'h00, seg}, 16'h0000);
        checkOutput("reset_sel", {8'h00, sel}, 16'h0000);
        checkOutput("reset_pulses", {14'h0, frame_valid, frame_err}, 16'h0000);
        checkOutput("reset_bitcnt", {11'h0, bit_cnt}, 16'h0000);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Loopback-style transmitter: empty latch first, then two frames
        latchFrame();
        checkOutput("empty_latch_seg", {seg, sel}, 16'h0000);
        applyStimulus(64'hA5FE, 16);
        expectValid(8'hA5, 8'hFE);
        latchFrame();
        checkOutput("loop1", {seg, sel}, 16'hA5FE);
        applyStimulus(64'h3C7F, 16);
        expectValid(8'h3C, 8'h7F);
        latchFrame();
        checkOutput("loop2", {seg, sel}, 16'h3C7F);

        // Direct drive
        applyStimulus(64'hC381, 16);
        checkOutput("direct_bitcnt16", {11'h0, bit_cnt}, 16'd16);
        expectValid(8'hC3, 8'h81);
        latchFrame();
        checkOutput("direct_data", {seg, sel}, 16'hC381);
        checkOutput("direct_bitcnt0", {11'h0, bit_cnt}, 16'd0);

        // Short frame
        applyStimulus(64'h2AB, 10);
        checkOutput("short_bitcnt", {11'h0, bit_cnt}, 16'd10);
        expectErr();
        latchFrame();
        checkOutput("short_hold", {seg, sel}, 16'hC381);
        checkOutput("short_bitcnt0", {11'h0, bit_cnt}, 16'd0);
        applyStimulus(64'h1234, 16);
        expectValid(8'h12, 8'h34);
        latchFrame();
        checkOutput("after_short", {seg, sel}, 16'h1234);

        // Overrun and saturation
        applyStimulus(64'hFFFFF, 20);
        checkOutput("overrun_bitcnt", {11'h0, bit_cnt}, 16'd20);
        expectErr();
        latchFrame();
        checkOutput("overrun_hold", {seg, sel}, 16'h1234);
        applyStimulus(64'h55_5555_5555, 40);
        checkOutput("saturate_bitcnt", {11'h0, bit_cnt}, 16'd31);
        expectErr();
        latchFrame();
        checkOutput("saturate_clear", {11'h0, bit_cnt}, 16'd0);

        // Simultaneous shift and latch
        applyStimulus(64'hBEEF, 16);
        dio_in = 1'b1;
        repeat (2) @(negedge clk);
        expectValid(8'hBE, 8'hEF);
        srclk_in = 1'b1;
        rclk_in  = 1'b1;
        repeat (2) @(negedge clk);
        srclk_in = 1'b0;
        rclk_in  = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("simul_data", {seg, sel}, 16'hBEEF);
        checkOutput("simul_bitcnt", {11'h0, bit_cnt}, 16'd1);
        expectErr();
        latchFrame();

        // Timeout
        applyStimulus(64'h15, 5);
        checkOutput("timeout_start", {11'h0, bit_cnt}, 16'd5);
        expectErr();
        repeat (1000) @(negedge clk);
        checkOutput("timeout_not_early", {11'h0, bit_cnt}, 16'd5);
        for (int i = 0; i < 200 && bit_cnt != 5'd0; i++) @(negedge clk);
        checkOutput("timeout_clear", {11'h0, bit_cnt}, 16'd0);
        checkOutput("timeout_hold", {seg, sel}, 16'hBEEF);

        // Reset mid-frame
        applyStimulus(64'hAA, 8);
        checkOutput("prereset_bitcnt", {11'h0, bit_cnt}, 16'd8);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_data", {seg, sel}, 16'h0000);
        checkOutput("midreset_bitcnt", {11'h0, bit_cnt}, 16'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        latchFrame();
        checkOutput("postreset_silent", {seg, sel}, 16'h0000);
        applyStimulus(64'h5AC3, 16);
        expectValid(8'h5A, 8'hC3);
        latchFrame();
        checkOutput("postreset_frame", {seg, sel}, 16'h5AC3);

        repeat (10) @(negedge clk);
        checkOutput("queue_drained", 16'(expQ.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
